// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: snoops an active-low multiplexed seven-segment scan bus and rebuilds the shown digits as BCD.
// Optional feature macro: SEG_DP_CAPTURE_EN (capture, compare and publish decimal points).

module seg_scan_decoder #(
  parameter logic [7:0] DIGIT_MASK    = 8'b0011_1111,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_en,
  input  logic [7:0]  seg_out,
  output logic [31:0] digits_bcd,
  output logic [7:0]  digits_valid,
  output logic [7:0]  dp,
  output logic        frame_done,
  output logic        update,
  output logic        enable_err
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [2:0] STABLE = 3'(STABLE_FRAMES);
`ifdef SEG_DP_CAPTURE_EN
  localparam logic [7:0] KEEP = 8'hFF;
`else
  localparam logic [7:0] KEEP = 8'h7F;
`endif

  logic [7:0]  en_r, en_d, seg_r;
  logic [3:0]  settle_q, settle_next;
  logic [7:0]  seen_q, seen_next;
  logic [7:0]  shadow_q    [8];
  logic [7:0]  shadow_next [8];
  logic [7:0]  ref_q       [8];
  logic [2:0]  match_q, match_next;
  logic        changed, legal_digit, illegal, fire;
  logic        complete, same, publish;
  logic [4:0]  dec;
  logic [31:0] pub_bcd;
  logic [7:0]  pub_valid, pub_dp;

  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h40:   decode_seg = 5'h10;
      7'h79:   decode_seg = 5'h11;
      7'h24:   decode_seg = 5'h12;
      7'h30:   decode_seg = 5'h13;
      7'h19:   decode_seg = 5'h14;
      7'h12:   decode_seg = 5'h15;
      7'h02:   decode_seg = 5'h16;
      7'h78:   decode_seg = 5'h17;
      7'h00:   decode_seg = 5'h18;
      7'h10:   decode_seg = 5'h19;
      default: decode_seg = 5'h0F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r  <= 8'hFF;
      en_d  <= 8'hFF;
      seg_r <= 8'hFF;
    end else begin
      en_r  <= seg_en;
      en_d  <= en_r;
      seg_r <= seg_out;
    end
  end

  // settle_next is the number of cycles the registered enable has held, including this one
  always_comb begin
    changed     = (en_r != en_d);
    legal_digit = $onehot(~en_r);
    illegal     = !legal_digit && (en_r != 8'hFF);
    if (changed)
      settle_next = 4'd1;
    else if (settle_q >= SETTLE)
      settle_next = settle_q;
    else
      settle_next = settle_q + 4'd1;
    fire = legal_digit && (settle_next == SETTLE) && (changed || (settle_q != SETTLE));
  end

  always_comb begin
    seen_next   = seen_q;
    shadow_next = shadow_q;
    if (fire) begin
      for (int i = 0; i < 8; i++) begin
        if (!en_r[i]) begin
          seen_next[i]   = 1'b1;
          shadow_next[i] = seg_r & KEEP;
        end
      end
    end
    complete = fire && ((seen_next & DIGIT_MASK) == DIGIT_MASK);

    same = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (DIGIT_MASK[i] && (shadow_next[i] != ref_q[i])) same = 1'b0;
    end
    if (!same)
      match_next = 3'd1;
    else if (match_q >= STABLE)
      match_next = match_q;
    else
      match_next = match_q + 3'd1;
    publish = complete && (match_next == STABLE);

    // unmasked positions stay zero so the readback never shows stale slots
    dec       = '0;
    pub_bcd   = '0;
    pub_valid = '0;
    pub_dp    = '0;
    for (int i = 0; i < 8; i++) begin
      if (DIGIT_MASK[i]) begin
        dec               = decode_seg(shadow_next[i][6:0]);
        pub_bcd[i*4 +: 4] = dec[3:0];
        pub_valid[i]      = dec[4];
`ifdef SEG_DP_CAPTURE_EN
        pub_dp[i]         = ~shadow_next[i][7];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q     <= '0;
      seen_q       <= '0;
      match_q      <= '0;
      enable_err   <= 1'b0;
      frame_done   <= 1'b0;
      update       <= 1'b0;
      digits_bcd   <= '0;
      digits_valid <= '0;
      dp           <= '0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        ref_q[i]    <= '0;
      end
    end else begin
      settle_q   <= settle_next;
      frame_done <= complete;
      update     <= 1'b0;
      shadow_q   <= shadow_next;
      if (illegal) enable_err <= 1'b1;
      if (complete) begin
        seen_q  <= '0;
        match_q <= match_next;
        if (!same) ref_q <= shadow_next;
      end else begin
        seen_q <= seen_next;
      end
      if (publish) begin
        digits_bcd   <= pub_bcd;
        digits_valid <= pub_valid;
        dp           <= pub_dp;
        update       <= (pub_bcd != digits_bcd) || (pub_valid != digits_valid) || (pub_dp != dp);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: drives scan dwells into seg_scan_decoder and checks it against a dwell/frame-level model.
// Honours SEG_DP_CAPTURE_EN the same way the design does.

module tb_seg_scan_decoder;

  localparam logic [7:0] MASK   = 8'b0011_1111;
  localparam int         SETTLE = 4;
  localparam int         STABLE = 2;
  localparam logic [6:0] PATS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef SEG_DP_CAPTURE_EN
  localparam bit DP_ON = 1'b1;
`else
  localparam bit DP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_en = 8'hFF;
  logic [7:0]  seg_out = 8'hFF;
  logic [31:0] digits_bcd;
  logic [7:0]  digits_valid, dp;
  logic        frame_done, update, enable_err;

  seg_scan_decoder #(
    .DIGIT_MASK   (MASK),
    .SETTLE_CYCLES(SETTLE),
    .STABLE_FRAMES(STABLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_en      (seg_en),
    .seg_out     (seg_out),
    .digits_bcd  (digits_bcd),
    .digits_valid(digits_valid),
    .dp          (dp),
    .frame_done  (frame_done),
    .update      (update),
    .enable_err  (enable_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_seen  = 0;
  int up_seen  = 0;

  // reference model state, kept per frame rather than per clock
  logic [7:0]  m_seen;
  logic [7:0]  m_shadow [8];
  logic [7:0]  m_ref    [8];
  bit          m_has_ref;
  int          m_match;
  logic [31:0] m_bcd;
  logic [7:0]  m_valid, m_dp;
  bit          m_err;
  int          m_frames  = 0;
  int          m_updates = 0;
  logic [7:0]  frame_segs [8];

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_seen++;
      if (update) up_seen++;
    end
  end

  function automatic logic [4:0] refDecode(input logic [6:0] s);
    refDecode = 5'h0F;
    for (int k = 0; k < 10; k++)
      if (PATS[k] == s) refDecode = {1'b1, 4'(k)};
  endfunction

  function automatic logic [7:0] digitSeg(input int v, input bit dp_lit);
    digitSeg = {~dp_lit, PATS[v]};
  endfunction

  task automatic modelReset();
    m_seen    = '0;
    m_has_ref = 1'b0;
    m_match   = 0;
    m_bcd     = '0;
    m_valid   = '0;
    m_dp      = '0;
    m_err     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_ref[i]    = '0;
    end
  endtask

  task automatic modelFrame();
    bit          same;
    logic [4:0]  r;
    logic [31:0] nb;
    logic [7:0]  nv, nd;
    m_frames++;
    m_seen = '0;
    same = m_has_ref;
    for (int i = 0; i < 8; i++)
      if (MASK[i] && m_shadow[i] != m_ref[i]) same = 1'b0;
    if (same) begin
      m_match = (m_match < STABLE) ? m_match + 1 : STABLE;
    end else begin
      m_match   = 1;
      m_has_ref = 1'b1;
      for (int i = 0; i < 8; i++) m_ref[i] = m_shadow[i];
    end
    if (m_match == STABLE) begin
      nb = '0; nv = '0; nd = '0;
      for (int i = 0; i < 8; i++) begin
        if (MASK[i]) begin
          r = refDecode(m_shadow[i][6:0]);
          nb[i*4 +: 4] = r[3:0];
          nv[i] = r[4];
          nd[i] = DP_ON && !m_shadow[i][7];
        end
      end
      if (nb != m_bcd || nv != m_valid || nd != m_dp) m_updates++;
      m_bcd = nb; m_valid = nv; m_dp = nd;
    end
  endtask

  task automatic modelDwell(input logic [7:0] en, input logic [7:0] seg, input int len);
    if (en == 8'hFF) return;
    if ($countones(~en) != 1) begin
      m_err = 1'b1;
      return;
    end
    if (len < SETTLE) return;
    for (int i = 0; i < 8; i++) begin
      if (!en[i]) begin
        m_shadow[i] = DP_ON ? seg : {1'b1, seg[6:0]};
        m_seen[i]   = 1'b1;
      end
    end
    if ((m_seen & MASK) == MASK) modelFrame();
  endtask

  task automatic applyStimulus(input logic [7:0] en, input logic [7:0] seg, input int len);
    seg_en  = en;
    seg_out = seg;
    repeat (len) @(negedge clk);
    modelDwell(en, seg, len);
  endtask

  task automatic applyGap();
    applyStimulus(8'hFF, 8'hFF, SETTLE + 3);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic checkState(input string tag);
    #1;
    checkOutput({tag, ".bcd"},     digits_bcd, m_bcd);
    checkOutput({tag, ".valid"},   32'(digits_valid), 32'(m_valid));
    checkOutput({tag, ".dp"},      32'(dp), 32'(m_dp));
    checkOutput({tag, ".err"},     32'(enable_err), 32'(m_err));
    checkOutput({tag, ".frames"},  32'(fd_seen), 32'(m_frames));
    checkOutput({tag, ".updates"}, 32'(up_seen), 32'(m_updates));
  endtask

  task automatic sendFrame(input int len);
    for (int d = 0; d < 6; d++) applyStimulus(~(8'(1) << d), frame_segs[d], len);
  endtask

  function automatic logic [7:0] randSeg();
    int k;
    logic [6:0] p;
    k = $urandom_range(0, 11);
    if (k < 10)       p = PATS[k];
    else if (k == 10) p = 7'h7F;
    else              p = 7'($urandom);
    randSeg = {($urandom_range(0, 3) != 0), p};
  endfunction

  task automatic randomIteration(input bit fresh);
    int         len;
    logic [7:0] en;
    if (fresh)
      for (int i = 0; i < 8; i++) frame_segs[i] = randSeg();
    for (int d = 0; d < 8; d++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 10);
      en  = ~(8'(1) << d);
      if ($urandom_range(0, 15) == 0) en = en & ~(8'(1) << ((d + 1) % 8));
      applyStimulus(en, frame_segs[d], len);
    end
    applyGap();
    checkState("rand");
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkState("reset");
    rst = 1'b0;
    applyGap();

    // steady 123456 with long dwells
    for (int i = 0; i < 8; i++) frame_segs[i] = (i < 6) ? digitSeg(i + 1, 1'b0) : 8'hFF;
    sendFrame(16); applyGap(); checkState("steady1");
    sendFrame(16); applyGap(); checkState("steady2");
    checkOutput("steady.bcd_const", digits_bcd, 32'h0065_4321);
    checkOutput("steady.valid_const", 32'(digits_valid), 32'h3F);
    sendFrame(16); applyGap(); checkState("steady3");

    // short digit-2 dwell must not complete the frame
    applyStimulus(8'b1111_1110, frame_segs[0], 8);
    applyStimulus(8'b1111_1101, frame_segs[1], 8);
    applyStimulus(8'b1111_1011, frame_segs[2], 2);
    applyStimulus(8'b1111_0111, frame_segs[3], 8);
    applyStimulus(8'b1110_1111, frame_segs[4], 8);
    applyStimulus(8'b1101_1111, frame_segs[5], 8);
    applyGap(); checkState("glitch_partial");
    applyStimulus(8'b1111_1011, frame_segs[2], 8);
    applyGap(); checkState("glitch_done");

    // illegal enable pattern
    applyStimulus(8'b1111_1100, digitSeg(8, 1'b0), 10);
    applyGap(); checkState("illegal");
    sendFrame(8); applyGap(); checkState("illegal_sticky");

    // blank pattern on digit 3
    frame_segs[3] = 8'hFF;
    sendFrame(6); applyGap();
    sendFrame(6); applyGap(); checkState("blank3");
    checkOutput("blank3.nibble", 32'(digits_bcd[15:12]), 32'hF);

    // frames A, B, B with dp lit on digit 2 in B
    for (int i = 0; i < 6; i++) frame_segs[i] = digitSeg(i + 1, 1'b0);
    sendFrame(5); applyGap(); checkState("dpA");
    frame_segs[2] = digitSeg(3, 1'b1);
    sendFrame(5); applyGap(); checkState("dpB1");
    sendFrame(5); applyGap(); checkState("dpB2");
    checkOutput("dp.const", 32'(dp), DP_ON ? 32'h04 : 32'h00);

    // reset in the middle of a frame
    for (int d = 0; d < 3; d++) applyStimulus(~(8'(1) << d), frame_segs[d], 8);
    applyGap();
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    checkState("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int d = 3; d < 6; d++) applyStimulus(~(8'(1) << d), frame_segs[d], 8);
    applyGap(); checkState("after_reset_partial");
    sendFrame(8); applyGap(); checkState("after_reset_full");

    for (int it = 0; it < 40; it++) randomIteration(it == 0 || $urandom_range(0, 2) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed seven-segment scanner: snoops the time-multiplexed `seg_en`/`seg_out` bus and reconstructs the displayed digits as BCD nibbles. It sits beside the clock/timer display path as a self-check and readback block, letting the time shown on the panel be compared against the counters or exported. Digits are published only after consecutive identical scan frames, so scan-transition glitches never reach the outputs.

## Interface
- `DIGIT_MASK`, 8'b0011_1111: digit positions that must be captured to complete a frame (bit i = `seg_en[i]`).
- `SETTLE_CYCLES`, 4: cycles a new `seg_en` value must hold unchanged before `seg_out` is sampled (range 1–15).
- `STABLE_FRAMES`, 2: consecutive identical frames required before publishing (range 1–7).

- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high.
- `seg_en` in 8: digit enables, active-low, one-hot-low while a digit is driven; all-ones = blank.
- `seg_out` in 8: segments, active-low, bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
- `digits_bcd` out 32: nibble i = decoded value of digit i.
- `digits_valid` out 8: bit i = 1 when digit i decoded to a legal 0–9 pattern.
- `dp` out 8: captured decimal points, active-high.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `update` out 1: one-cycle pulse when published outputs change.
- `enable_err` out 1: sticky; set on an illegal `seg_en` value.

## Operation
- `seg_en` and `seg_out` are registered once on entry; all logic uses the registered copies.
- Settle tracker: a 4-bit counter resets to 1 whenever registered `seg_en` differs from its previous value and increments while it holds. Reaching `SETTLE_CYCLES` samples `seg_out` into shadow slot i, sets `seen[i]`, and stops counting until `seg_en` changes again. Exactly one sample per enable dwell.
- All-ones `seg_en`: no sampling, no error. Any other value that is not one-hot-low sets `enable_err`. No sampling; the counter restarts on the next change. Positions outside `DIGIT_MASK` are sampled but never gate frame completion.
- Frame complete when `(seen & DIGIT_MASK) == DIGIT_MASK`: pulse `frame_done`, clear `seen`. If shadow (masked slots) equals the previous frame's shadow, increment the match counter; otherwise set it to 1 and store the shadow as the new reference. When the match counter reaches `STABLE_FRAMES`, publish decoded shadow to outputs; pulse `update` only if `digits_bcd`, `digits_valid` or `dp` change. The match counter saturates.
- Decode of `seg_out[6:0]`: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Any other pattern, including blank 7'h7F, yields nibble 4'hF with the valid bit cleared.
- Unmasked digit outputs remain 4'h0, with valid and dp bits 0.

## Timing
- Reset: `digits_bcd`=0, `digits_valid`=0, `dp`=0, `frame_done`=0, `update`=0, `enable_err`=0. `seen`, shadows and counters are cleared. Reset mid-frame discards the partial frame.
- Sample latency: `seg_en` change at pin edge N is registered at N+1. The sample is taken at edge N+1+`SETTLE_CYCLES`−1.
- A dwell shorter than `SETTLE_CYCLES` registered cycles is never sampled.
- `frame_done` asserts the cycle after the last required sample. Publish and `update` occur in the same cycle as that `frame_done`.
- A re-sample of an already-seen digit within a frame overwrites its slot (last value wins).
- `enable_err` clears only on `rst`.

## Configuration
- `SEG_DP_CAPTURE_EN` defined: `seg_out[7]` is stored per slot, participates in the frame-equality check, and is published on `dp` (active-high = dp lit).
- Not defined: `seg_out[7]` is ignored entirely, `dp` is tied to 8'h00, and dp toggling never breaks frame stability.

## Test plan
- Reset: assert `rst` mid-scan -> all outputs 0 next edge. No `frame_done` until a full new frame completes.
- Steady "123456" on digits 0–5, 16-cycle dwell, three frames -> publish after frame 2 with `digits_bcd`=32'h0065_4321, `digits_valid`=8'h3F, and a single `update` pulse. Frame 3 produces `frame_done` only.
- Glitch: digit 2 enabled for 2 cycles (<4), then full dwells -> the short dwell is not sampled, and the frame completes only after a proper digit-2 dwell.
- Illegal `seg_en`=8'b1111_1100 for 10 cycles -> `enable_err`=1 (sticky), no sampling, `seen` unchanged.
- Pattern 7'h7F on digit 3 for two frames -> nibble 3 = 4'hF and `digits_valid` bit 3 = 0, with other digits decoded normally.
- Frames A,B,B with `SEG_DP_CAPTURE_EN` defined and dp lit on digit 2 in B -> publish after the second B with `dp`=8'h04. With the macro undefined, `dp`=8'h00 and a dp-only difference between A and B still counts as matching.
